mul255_scheduler: RTL

- Shares one 255-bit field multiplier (serial 17-bit-digit multiplier with modular reduction, result on `mul_out`) between two requesters, e.g. the point-add and point-double units of the ECC core.
- Arbitrates round-robin and latches the operands so they stay stable for the whole multiply.
- Pulses the multiplier load, counts its fixed latency, captures the reduced product and returns it with a requester ID over a valid/ready handshake.

---
 rtl/mul255_scheduler.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mul255_scheduler.sv
// mul255_scheduler: lets two requesters share one serial 255-bit modular
// multiplier. Round-robin grant, operands latched for the whole multiply,
// fixed-latency result capture and a valid/ready response carrying the
// owner's ID.
module mul255_scheduler #(
  parameter int W        = 255,
  parameter int MUL_LAT  = 20,
  parameter int LOAD_CYC = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_data,
  output logic         mul_load,
  output logic [W-1:0] mul_a,
  output logic [W-1:0] mul_b,
  input  logic [W-1:0] mul_out,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t       state_reg;
  state_t       state_next;
  logic         rr_reg;
  logic [1:0]   load_cnt_reg;
  logic [5:0]   lat_cnt_reg;
  logic [W-1:0] op_a_reg;
  logic [W-1:0] op_b_reg;
  logic [W-1:0] rsp_data_reg;
  logic         id_reg;

  logic         grant_en;
  logic         grant_id;
  logic         load_last;
  logic         lat_last;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;

  assign req_valid = {req1_valid, req0_valid};
  assign load_last = (load_cnt_reg == 2'(LOAD_CYC - 1));
  assign lat_last  = (lat_cnt_reg == 6'(MUL_LAT - 1));

  // Arbitration in IDLE and the state sequencing for LOAD/RUN/DONE.
  always_comb begin
    state_next = state_reg;
    grant_en   = 1'b0;
    grant_id   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (&req_valid) begin
          grant_en = 1'b1;
          grant_id = rr_reg;
        end else if (req_valid[0]) begin
          grant_en = 1'b1;
          grant_id = 1'b0;
        end else if (req_valid[1]) begin
          grant_en = 1'b1;
          grant_id = 1'b1;
        end
        if (grant_en) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (load_last) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (lat_last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Ready pulses are combinational; gating with rst keeps them low while
  // reset is asserted even if a requester is already valid.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ready
      assign req_ready[gi] = rst & grant_en & (grant_id == 1'(gi));
    end
  endgenerate

  assign req0_ready = req_ready[0];
  assign req1_ready = req_ready[1];

  // Control state: FSM, load/latency counters and round-robin pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      rr_reg       <= 1'b0;
      load_cnt_reg <= '0;
      lat_cnt_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      load_cnt_reg <= (state_reg == LOAD && !load_last) ? load_cnt_reg + 2'd1 : '0;
      lat_cnt_reg  <= (state_reg == RUN && !lat_last) ? lat_cnt_reg + 6'd1 : '0;
      // The requester just served drops to lowest priority.
      if (state_reg == DONE && rsp_ready) begin
        rr_reg <= ~id_reg;
      end
    end
  end

  // Datapath: operands/ID latched on grant, product captured at end of RUN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_a_reg     <= '0;
      op_b_reg     <= '0;
      id_reg       <= 1'b0;
      rsp_data_reg <= '0;
    end else begin
      if (grant_en) begin
        op_a_reg <= grant_id ? req1_a : req0_a;
        op_b_reg <= grant_id ? req1_b : req0_b;
        id_reg   <= grant_id;
      end
      if (state_reg == RUN && lat_last) begin
        rsp_data_reg <= mul_out;
      end
    end
  end

  assign mul_load  = (state_reg == LOAD);
  assign mul_a     = op_a_reg;
  assign mul_b     = op_b_reg;
  assign rsp_valid = (state_reg == DONE);
  assign rsp_id    = id_reg;
  assign rsp_data  = rsp_data_reg;
  assign busy      = (state_reg != IDLE);

endmodule
